// File: rtl/operand_entry_seq.sv
// operand_entry_seq
//   Operand-entry front end for the 3-bit ripple adder on the DE2 board.
//   The operator sets a value on the slide switches and presses KEY0 once
//   per operand. KEY0 is synchronised and debounced. Each accepted press
//   advances LOAD_A -> LOAD_B -> SHOW -> LOAD_A and captures the
//   synchronised switch value into OPA or OPB.
//
// Ports
//   CLOCK_50  in   1  single clock, rising edge
//   RESET     in   1  synchronous, active-high
//   SW        in   3  raw slide switches (asynchronous)
//   KEY0      in   1  raw pushbutton, active-low, bouncy (asynchronous)
//   OPA       out  3  captured operand A (registered)
//   OPB       out  3  captured operand B (registered)
//   VALID     out  1  high while OPA/OPB hold a complete pair (registered)
//   STATE_LED out  2  FSM state: LOAD_A=00, LOAD_B=01, SHOW=10 (registered)
module operand_entry_seq #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [2:0] SW,
  input  logic       KEY0,
  output logic [2:0] OPA,
  output logic [2:0] OPB,
  output logic       VALID,
  output logic [1:0] STATE_LED
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    SHOW   = 2'b10
  } state_t;

  logic          key_s1, key_s2;
  logic [2:0]    sw_s1, sw_s2;
  logic          key_db, key_db_d;
  logic [CW-1:0] cnt;
  logic          press;

  state_t     state, state_nx;
  logic [2:0] opa_nx, opb_nx;
  logic       valid_nx;

  // Falling edge of the debounced level; a release produces no event.
  assign press     = key_db_d & ~key_db;
  assign STATE_LED = state;

  // Synchronisers, debouncer and edge-detect delay.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      key_s1   <= 1'b1;
      key_s2   <= 1'b1;
      sw_s1    <= '0;
      sw_s2    <= '0;
      key_db   <= 1'b1;
      key_db_d <= 1'b1;
      cnt      <= '0;
    end else begin
      key_s1   <= KEY0;
      key_s2   <= key_s1;
      sw_s1    <= SW;
      sw_s2    <= sw_s1;
      key_db_d <= key_db;
      // Any sample that agrees with the debounced level restarts the count.
      if (key_s2 != key_db) begin
        if (cnt == CNT_LAST) begin
          key_db <= ~key_db;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // FSM state and registered operand outputs.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state <= LOAD_A;
      OPA   <= '0;
      OPB   <= '0;
      VALID <= 1'b0;
    end else begin
      state <= state_nx;
      OPA   <= opa_nx;
      OPB   <= opb_nx;
      VALID <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    opa_nx   = OPA;
    opb_nx   = OPB;
    valid_nx = VALID;
    if (press) begin
      case (state)
        LOAD_A: begin
          opa_nx   = sw_s2;
          state_nx = LOAD_B;
        end
        LOAD_B: begin
          opb_nx   = sw_s2;
          valid_nx = 1'b1;
          state_nx = SHOW;
        end
        SHOW: begin
          valid_nx = 1'b0;
          state_nx = LOAD_A;
        end
        default: begin
          valid_nx = 1'b0;
          state_nx = LOAD_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_entry_seq.sv
// Testbench for operand_entry_seq with DEBOUNCE_CYCLES = 4.
// A reference model updated on every rising edge pushes the expected
// outputs into a queue; a monitor on the falling edge pops and compares.
// Directed scenarios are followed by randomized KEY0/SW/RESET traffic, and
// a few absolute checks confirm the operand values of directed scenarios.
module tb_operand_entry_seq;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sw;
  logic       key;
  logic [2:0] opa, opb;
  logic       valid;
  logic [1:0] state_led;

  int tests = 0;
  int fails = 0;

  logic [8:0] expq[$];

  operand_entry_seq #(.DEBOUNCE_CYCLES(D)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .SW       (sw),
    .KEY0     (key),
    .OPA      (opa),
    .OPB      (opb),
    .VALID    (valid),
    .STATE_LED(state_led)
  );

  always #5 clk = ~clk;

  // Reference model: the button level seen two samples late must disagree
  // with the accepted level for D consecutive samples to be accepted; an
  // accepted fall is acted on one cycle later. Operand entry is a mod-3 step.
  initial begin : model
    logic       k1, k2, db, dbd, mv;
    logic [2:0] s1, s2, ma, mb;
    int         run, st;
    k1 = 1'b1; k2 = 1'b1; db = 1'b1; dbd = 1'b1; mv = 1'b0;
    s1 = '0; s2 = '0; ma = '0; mb = '0; run = 0; st = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        k1 = 1'b1; k2 = 1'b1; db = 1'b1; dbd = 1'b1; mv = 1'b0;
        s1 = '0; s2 = '0; ma = '0; mb = '0; run = 0; st = 0;
      end else begin
        if (dbd && !db) begin
          if (st == 0) ma = s2;
          if (st == 1) begin mb = s2; mv = 1'b1; end
          if (st == 2) mv = 1'b0;
          st = (st + 1) % 3;
        end
        dbd = db;
        if (k2 != db) begin
          run++;
          if (run == D) begin
            db  = ~db;
            run = 0;
          end
        end else begin
          run = 0;
        end
        k2 = k1; k1 = key;
        s2 = s1; s1 = sw;
      end
      expq.push_back({ma, mb, mv, 2'(st)});
    end
  end

  // Monitor.
  initial begin : monitor
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        tests++;
        if ({opa, opb, valid, state_led} !== e) begin
          fails++;
          $display("FAIL cycle_check t=%0t: got opa=%b opb=%b valid=%b state=%b, want opa=%b opb=%b valid=%b state=%b",
                   $time, opa, opb, valid, state_led, e[8:6], e[5:3], e[2], e[1:0]);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_clean(input logic [2:0] v);
    sw  = v;
    key = 1'b0;
    cyc(10);
    key = 1'b1;
    cyc(10);
  endtask

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  initial begin : stim
    rst = 1'b1;
    key = 1'b0;
    sw  = 3'b111;
    cyc(2);
    chk("reset", {opa, opb, valid, state_led}, {3'b000, 3'b000, 1'b0, 2'b00});
    rst = 1'b0;
    key = 1'b1;
    cyc(6);

    press_clean(3'b101);
    chk("opa_first", {opa, opb, valid, state_led}, {3'b101, 3'b000, 1'b0, 2'b01});
    press_clean(3'b110);
    chk("opb_pair", {opa, opb, valid, state_led}, {3'b101, 3'b110, 1'b1, 2'b10});
    press_clean(3'b000);
    chk("wrap_show", {opa, opb, valid, state_led}, {3'b101, 3'b110, 1'b0, 2'b00});
    press_clean(3'b011);
    chk("opa_after_wrap", {opa, opb, valid, state_led}, {3'b011, 3'b110, 1'b0, 2'b01});

    // Bounce: five short lows, then a stable low; one capture into OPB.
    sw = 3'b010;
    for (int i = 0; i < 5; i++) begin
      key = 1'b0; cyc(2);
      key = 1'b1; cyc(1);
    end
    key = 1'b0; cyc(10);
    key = 1'b1; cyc(10);
    chk("bounce_one_event", {opa, opb, valid, state_led}, {3'b011, 3'b010, 1'b1, 2'b10});
    press_clean(3'b000);

    // Long hold in LOAD_A.
    sw = 3'b100;
    key = 1'b0; cyc(100);
    key = 1'b1; cyc(10);
    chk("long_hold", {opa, opb, valid, state_led}, {3'b100, 3'b010, 1'b0, 2'b01});

    // Reset pulsed on edge 3 of a debounce, key still held.
    sw  = 3'b001;
    key = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(5);
    chk("no_capture_after_reset", {opa, opb, valid, state_led}, {3'b000, 3'b000, 1'b0, 2'b00});
    cyc(10);
    key = 1'b1;
    cyc(10);
    chk("capture_after_reset", {opa, opb, valid, state_led}, {3'b001, 3'b000, 1'b0, 2'b01});

    // Randomized traffic, including occasional resets and near-threshold pulses.
    for (int seg = 0; seg < 250; seg++) begin
      int len;
      key = ~key;
      len = $urandom_range(1, 9);
      for (int c = 0; c < len; c++) begin
        sw  = 3'($urandom_range(0, 7));
        rst = ($urandom_range(0, 99) == 0);
        cyc(1);
      end
      rst = 1'b0;
    end
    key = 1'b1;
    cyc(12);

    chk("queue_drained", 9'(expq.size() <= 1), 9'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
